// File: rtl/div_sequencer.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle through a shared
// subtractor, start/busy/done handshake, RISC-V divide-by-zero results.
module div_sequencer #(
  parameter int unsigned NUM_SIZE = 32
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                start,
  input  logic [NUM_SIZE-1:0] dividend,
  input  logic [NUM_SIZE-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [NUM_SIZE-1:0] quotient,
  output logic [NUM_SIZE-1:0] remainder,
  output logic                divByZero
);

  localparam int unsigned CW = $clog2(NUM_SIZE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              r_state, w_next;
  logic [NUM_SIZE-1:0] r_R, r_Q, r_div;
  logic [NUM_SIZE-1:0] r_quot, r_rem;
  logic                r_dbz;
  logic [CW-1:0]       r_cnt;

  logic [NUM_SIZE:0]   w_T, w_D;
  logic [NUM_SIZE-1:0] w_Rn, w_Qn;
  logic                w_borrow, w_accept, w_zero, w_last;

  // Restoring step: a borrow implies T < 2^NUM_SIZE, so dropping T's MSB is lossless.
  always_comb begin
    w_T      = {r_R, r_Q[NUM_SIZE-1]};
    w_D      = w_T + ~{1'b0, r_div} + {{NUM_SIZE{1'b0}}, 1'b1};
    w_borrow = w_D[NUM_SIZE];
    w_Rn     = w_borrow ? w_T[NUM_SIZE-1:0] : w_D[NUM_SIZE-1:0];
    w_Qn     = {r_Q[NUM_SIZE-2:0], ~w_borrow};
    w_accept = start && (r_state != S_RUN);
    w_zero   = (divisor == '0);
    w_last   = (r_cnt == CW'(1));
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = w_zero ? S_DONE : S_RUN;
      S_RUN:  if (w_last) w_next = S_DONE;
      S_DONE: begin
        if (start) w_next = w_zero ? S_DONE : S_RUN;
        else       w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state <= S_IDLE;
      r_R     <= '0;
      r_Q     <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_div <= divisor;
        r_R   <= '0;
        r_Q   <= dividend;
        r_cnt <= CW'(NUM_SIZE);
        if (w_zero) begin
          r_quot <= '1;
          r_rem  <= dividend;
          r_dbz  <= 1'b1;
        end
      end else if (r_state == S_RUN) begin
        r_R   <= w_Rn;
        r_Q   <= w_Qn;
        r_cnt <= r_cnt - CW'(1);
        if (w_last) begin
          r_quot <= w_Qn;
          r_rem  <= w_Rn;
          r_dbz  <= 1'b0;
        end
      end
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign divByZero = r_dbz;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: vector table plus handshake/reset sequences,
// results scoreboarded through a queue and compared when done pulses.
module tb_div_sequencer;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rstN, start;
  logic [N-1:0] dividend, divisor;
  logic         busy, done, divByZero;
  logic [N-1:0] quotient, remainder;

  div_sequencer #(.NUM_SIZE(N)) dut (
    .clk(clk), .rstN(rstN), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .divByZero(divByZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } vec_t;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } res_t;

  res_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  logic [N-1:0] prev_q = '0, prev_r = '0;
  logic         prev_z = 1'b0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard consumer: one expected record per done cycle.
  always @(negedge clk) begin
    if (rstN === 1'b1 && done === 1'b1) begin
      chk("done_busy_excl", {31'b0, busy}, '0);
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected_done: got done with empty scoreboard, expected none");
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("divByZero", {31'b0, divByZero}, {31'b0, e.z});
      end
    end
  end

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] eq, input logic [N-1:0] er, input logic ez);
    int   lat;
    int   busy_n;
    res_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.q = eq; e.r = er; e.z = ez;
    sb.push_back(e);
    lat = 0;
    busy_n = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        if (b != '0) begin
          chk("hold_q_in_run", quotient, prev_q);
          chk("hold_r_in_run", remainder, prev_r);
          chk("hold_z_in_run", {31'b0, divByZero}, {31'b0, prev_z});
        end
      end
      if (busy) busy_n++;
    end while (!done && lat < 100);
    chk("latency", lat, (b == '0) ? 32'd1 : 32'd33);
    chk("busy_cycles", busy_n, (b == '0) ? 32'd0 : 32'd32);
    @(negedge clk);
    prev_q = eq; prev_r = er; prev_z = ez;
  endtask

  vec_t vt[$];

  initial begin
    int   lat;
    int   dn;
    vec_t v;
    rstN = 1'b0; start = 1'b0; dividend = '0; divisor = '0;

    vt.push_back('{32'd100,        32'd7,          32'd14,         32'd2,          1'b0});
    vt.push_back('{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0});
    vt.push_back('{32'd3,          32'd10,         32'd0,          32'd3,          1'b0});
    vt.push_back('{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1});
    vt.push_back('{32'd0,          32'd5,          32'd0,          32'd0,          1'b0});
    vt.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0});
    vt.push_back('{32'd1000,       32'd10,         32'd100,        32'd0,          1'b0});
    vt.push_back('{32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF,  32'h0000_FFFF,  1'b0});
    vt.push_back('{32'h8000_0000,  32'd3,          32'd715827882,  32'd2,          1'b0});
    vt.push_back('{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1});
    for (int i = 0; i < 4; i++) begin
      v.a = $urandom;
      v.b = (i < 2) ? 32'($urandom_range(1, 5000)) : ($urandom | 32'd1);
      v.q = v.a / v.b;
      v.r = v.a % v.b;
      v.z = 1'b0;
      vt.push_back(v);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, '0);
    chk("rst_done", {31'b0, done}, '0);
    chk("rst_quotient", quotient, '0);
    chk("rst_remainder", remainder, '0);
    chk("rst_divByZero", {31'b0, divByZero}, '0);
    rstN = 1'b1;

    foreach (vt[i]) run_op(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].z);

    // Results from a divide-by-zero persist through idle.
    run_op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    repeat (4) @(negedge clk);
    chk("idle_hold_z", {31'b0, divByZero}, 32'd1);
    chk("idle_hold_r", remainder, 32'd5);

    // Start during RUN is ignored; start held in DONE chains a new operation.
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    sb.push_back('{32'd14, 32'd2, 1'b0});
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) start = 1'b0;
      if (lat == 10) begin
        dividend = 32'd9; divisor = 32'd2; start = 1'b1;
      end
      if (lat == 11) begin
        start = 1'b0;
        chk("start_ignored_busy", {31'b0, busy}, 32'd1);
      end
    end while (!done && lat < 100);
    chk("hs_latency1", lat, 32'd33);
    dividend = 32'd9; divisor = 32'd2; start = 1'b1;
    sb.push_back('{32'd4, 32'd1, 1'b0});
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    chk("b2b_done_low", {31'b0, done}, '0);
    chk("b2b_hold_q", quotient, 32'd14);
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("hs_latency2", lat, 32'd33);
    @(negedge clk);

    // Reset in the middle of RUN aborts without a done pulse.
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("pre_reset_busy", {31'b0, busy}, 32'd1);
    rstN = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", {31'b0, busy}, '0);
    chk("mid_rst_done", {31'b0, done}, '0);
    chk("mid_rst_quotient", quotient, '0);
    chk("mid_rst_remainder", remainder, '0);
    rstN = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("no_done_after_reset", dn, '0);
    chk("sb_drained", sb.size(), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
